// File: rtl/jt12_mod_hist.sv
// jt12_mod_hist
//   Operator-output history and modulation-input generator for the FM
//   operator pipeline. Walks the slot order S1, S3, S2, S4 (num_ch channels
//   each), keeps per-channel history of operator outputs, and registers the
//   x+y modulation sum picked by the selector's xuse/yuse flags.
//
// Parameters
//   num_ch : channels per operator group (6 or 3); a frame is 4*num_ch slots
//   OPW    : signed operator output width
//
// Ports
//   rst                 : asynchronous reset, active-high
//   clk                 : system clock
//   clk_en              : slot advance / history write enable
//   zero                : frame sync, next slot is slot 0
//   op_result           : signed operator output of the current slot
//   xuse_* / yuse_*     : source selects from the modulation selector
//   s1..s4_enters       : registered one-hot slot-group flags
//   cur_ch              : registered channel index of the current slot
//   mod_sum             : registered signed x+y modulation value
//   use_err             : sticky flag, more than one x or y source selected
//
// Build option
//   JT12_MODSUM_SAT_EN  : clamp x+y to the signed OPW range before registering

module jt12_mod_hist #(
    parameter int num_ch = 6,
    parameter int OPW    = 14
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic                  clk_en,
    input  logic                  zero,
    input  logic signed [OPW-1:0] op_result,
    input  logic                  xuse_prevprev1,
    input  logic                  xuse_prev2,
    input  logic                  xuse_internal,
    input  logic                  yuse_prev1,
    input  logic                  yuse_prev2,
    input  logic                  yuse_internal,
    output logic                  s1_enters,
    output logic                  s2_enters,
    output logic                  s3_enters,
    output logic                  s4_enters,
    output logic [2:0]            cur_ch,
    output logic signed [OPW:0]   mod_sum,
    output logic                  use_err
);

    // One-hot group encoding: each bit is directly one of the enters flags,
    // so the flags come straight from the state register.
    typedef enum logic [3:0] {
        GRP_S1 = 4'b0001,
        GRP_S2 = 4'b0010,
        GRP_S3 = 4'b0100,
        GRP_S4 = 4'b1000
    } grp_e;

    localparam logic [2:0] LAST_CH = 3'(num_ch - 1);

    grp_e       grp_q, grp_d;
    logic [2:0] ch_q, ch_d;

    logic signed [OPW-1:0] s1_last_q [num_ch];
    logic signed [OPW-1:0] s1_prev_q [num_ch];
    logic signed [OPW-1:0] s2_last_q [num_ch];
    logic signed [OPW-1:0] s3_last_q [num_ch];

    logic signed [OPW:0]   mod_sum_q, mod_sum_d;
    logic                  use_err_q, use_err_d;

    // Slot counter kept as (group, channel); slot_cnt = group*num_ch + ch.
    always_comb begin
        grp_d = grp_q;
        ch_d  = ch_q;
        if (zero) begin
            grp_d = GRP_S1;
            ch_d  = '0;
        end else if (ch_q == LAST_CH) begin
            ch_d = '0;
            case (grp_q)
                GRP_S1:  grp_d = GRP_S3;
                GRP_S3:  grp_d = GRP_S2;
                GRP_S2:  grp_d = GRP_S4;
                default: grp_d = GRP_S1;
            endcase
        end else begin
            ch_d = ch_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q <= GRP_S1;
            ch_q  <= '0;
        end else if (clk_en) begin
            grp_q <= grp_d;
            ch_q  <= ch_d;
        end
    end

    // History read is of the pre-write contents of the current channel.
    logic signed [OPW-1:0] prevprev1, prev1, prev2, internal;
    logic signed [OPW-1:0] x, y;
    logic signed [OPW:0]   sum_full;
    logic                  multi_x, multi_y;

    always_comb begin
        prev1     = s1_last_q[ch_q];
        prev2     = s2_last_q[ch_q];
        internal  = s3_last_q[ch_q];
        prevprev1 = (grp_q == GRP_S1) ? s1_prev_q[ch_q] : s1_last_q[ch_q];

        // OR-combination keeps the result X-free even under over-use.
        x = ({OPW{xuse_prevprev1}} & prevprev1)
          | ({OPW{xuse_prev2}}     & prev2)
          | ({OPW{xuse_internal}}  & internal);
        y = ({OPW{yuse_prev1}}     & prev1)
          | ({OPW{yuse_prev2}}     & prev2)
          | ({OPW{yuse_internal}}  & internal);

        sum_full = {x[OPW-1], x} + {y[OPW-1], y};

`ifdef JT12_MODSUM_SAT_EN
        // Overflow out of the OPW range shows as the top two bits differing.
        if (sum_full[OPW] != sum_full[OPW-1])
            mod_sum_d = sum_full[OPW] ? {2'b11, {(OPW-1){1'b0}}}
                                      : {2'b00, {(OPW-1){1'b1}}};
        else
            mod_sum_d = sum_full;
`else
        mod_sum_d = sum_full;
`endif

        multi_x = (xuse_prevprev1 & xuse_prev2) | (xuse_prevprev1 & xuse_internal)
                | (xuse_prev2 & xuse_internal);
        multi_y = (yuse_prev1 & yuse_prev2) | (yuse_prev1 & yuse_internal)
                | (yuse_prev2 & yuse_internal);
        use_err_d = use_err_q | multi_x | multi_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < num_ch; i++) begin
                s1_last_q[i] <= '0;
                s1_prev_q[i] <= '0;
                s2_last_q[i] <= '0;
                s3_last_q[i] <= '0;
            end
        end else if (clk_en) begin
            case (grp_q)
                GRP_S1: begin
                    s1_prev_q[ch_q] <= s1_last_q[ch_q];
                    s1_last_q[ch_q] <= op_result;
                end
                GRP_S3:  s3_last_q[ch_q] <= op_result;
                GRP_S2:  s2_last_q[ch_q] <= op_result;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_sum_q <= '0;
            use_err_q <= 1'b0;
        end else if (clk_en) begin
            mod_sum_q <= mod_sum_d;
            use_err_q <= use_err_d;
        end
    end

    assign s1_enters = grp_q[0];
    assign s2_enters = grp_q[1];
    assign s3_enters = grp_q[2];
    assign s4_enters = grp_q[3];
    assign cur_ch    = ch_q;
    assign mod_sum   = mod_sum_q;
    assign use_err   = use_err_q;

endmodule

// File: tb/tb_jt12_mod_hist.sv
// Directed bench for jt12_mod_hist with num_ch=6, OPW=14.

module tb_jt12_mod_hist;

    logic               rst, clk, clk_en, zero;
    logic signed [13:0] op_result;
    logic xuse_prevprev1, xuse_prev2, xuse_internal;
    logic yuse_prev1, yuse_prev2, yuse_internal;
    logic s1_enters, s2_enters, s3_enters, s4_enters;
    logic [2:0]         cur_ch;
    logic signed [14:0] mod_sum;
    logic               use_err;

    int nvec = 0;
    int nerr = 0;
    int k    = 0;   // current slot as the bench expects it
    int f    = 1;   // frame number since the stimulus began
    logic signed [31:0] sat_exp;

    jt12_mod_hist #(.num_ch(6), .OPW(14)) dut (
        .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero),
        .op_result(op_result),
        .xuse_prevprev1(xuse_prevprev1), .xuse_prev2(xuse_prev2),
        .xuse_internal(xuse_internal),
        .yuse_prev1(yuse_prev1), .yuse_prev2(yuse_prev2),
        .yuse_internal(yuse_internal),
        .s1_enters(s1_enters), .s2_enters(s2_enters),
        .s3_enters(s3_enters), .s4_enters(s4_enters),
        .cur_ch(cur_ch), .mod_sum(mod_sum), .use_err(use_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // {s1,s2,s3,s4} for a slot: groups run S1, S3, S2, S4.
    function automatic logic [3:0] exp_enters(input int kk);
        case (kk / 6)
            0:       return 4'b1000;
            1:       return 4'b0010;
            2:       return 4'b0100;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic signed [13:0] opval(input int ff, input int kk);
        if (kk == 0) begin
            case (ff)
                1: return 14'sd100;
                2: return 14'sd300;
                3: return 14'sd77;
                4: return 14'sd55;
                5: return 14'sd11;
                6: return 14'sd22;
                default: return 14'sd0;
            endcase
        end
        if (ff <= 5 && kk == 8)  return -14'sd50;
        if (ff <= 5 && kk == 14) return 14'sd20;
        if (ff == 3 && (kk == 1 || kk == 7)) return 14'sd8000;
        if (ff == 5 && kk == 12) return 14'sd999;
        return 14'sd0;
    endfunction

    task automatic clr_flags;
        xuse_prevprev1 = 0; xuse_prev2 = 0; xuse_internal = 0;
        yuse_prev1 = 0; yuse_prev2 = 0; yuse_internal = 0;
    endtask

    // One clock: drive this slot's op_result, then check slot position.
    task automatic slot;
        op_result = opval(f, k);
        @(posedge clk);
        #1;
        if (clk_en) begin
            if (zero || k == 23) begin
                k = 0;
                f = f + 1;
            end else begin
                k = k + 1;
            end
        end
        chk("enters", {s1_enters, s2_enters, s3_enters, s4_enters}, exp_enters(k));
        chk("cur_ch", cur_ch, k % 6);
    endtask

    initial begin
`ifdef JT12_MODSUM_SAT_EN
        sat_exp = 8191;
`else
        sat_exp = 16000;
`endif
        rst = 1; clk_en = 0; zero = 0; op_result = '0;
        clr_flags();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enters", {s1_enters, s2_enters, s3_enters, s4_enters}, 4'b1000);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_mod_sum", mod_sum, 0);
        chk("rst_use_err", use_err, 0);
        rst = 0;
        clk_en = 1;

        // Frames 1 and 2: slot walk with wrap, history filled.
        repeat (48) slot();
        chk("mod_sum_idle", mod_sum, 0);

        // Frame 3, ch0 S1: s1_prev=100, s1_last=300.
        xuse_prevprev1 = 1; yuse_prev1 = 1;
        slot();
        clr_flags();
        chk("feedback_400", mod_sum, 400);
        slot();
        chk("no_flags_0", mod_sum, 0);

        // Frame 3, S4 ch2: internal=-50, prev2=20.
        repeat (18) slot();
        xuse_internal = 1; yuse_prev2 = 1;
        slot();
        clr_flags();
        chk("s4_ch2_m30", mod_sum, -30);

        // clk_en low: nothing moves, over-use not latched.
        clk_en = 0;
        xuse_prev2 = 1; xuse_internal = 1;
        repeat (2) slot();
        chk("hold_mod_sum", mod_sum, -30);
        chk("hold_use_err", use_err, 0);
        clr_flags();
        clk_en = 1;

        // Frame 4, S1 ch1: prev1=8000, internal=8000.
        repeat (4) slot();
        xuse_internal = 1; yuse_prev1 = 1;
        slot();
        clr_flags();
        chk("sum_16000", mod_sum, sat_exp);

        // zero at slot 3 truncates the frame; the slot check sees slot 0.
        slot();
        zero = 1;
        slot();
        zero = 0;

        // History survives the truncation: s1_prev=77, s1_last=55.
        xuse_prevprev1 = 1; yuse_prev1 = 1;
        slot();
        clr_flags();
        chk("after_zero_132", mod_sum, 132);
        chk("use_err_clean", use_err, 0);

        xuse_prev2 = 1; xuse_internal = 1;
        slot();
        clr_flags();
        chk("use_err_set", use_err, 1);

        repeat (11) slot();
        chk("use_err_sticky", use_err, 1);
        repeat (11) slot();
        repeat (8) slot();
        xuse_internal = 1;
        slot();
        clr_flags();
        chk("pre_rst_m50", mod_sum, -50);
        chk("pre_rst_k9", k, 9);

        // Asynchronous reset in the middle of slot 9.
        #2 rst = 1;
        #1;
        chk("arst_enters", {s1_enters, s2_enters, s3_enters, s4_enters}, 4'b1000);
        chk("arst_cur_ch", cur_ch, 0);
        chk("arst_mod_sum", mod_sum, 0);
        chk("arst_use_err", use_err, 0);
        @(negedge clk);
        rst = 0;
        k = 0;
        f = 7;

        // History cleared: old s1_prev=11, s1_last=22 must read as 0.
        xuse_prevprev1 = 1; yuse_prev1 = 1;
        slot();
        clr_flags();
        chk("post_rst_s1", mod_sum, 0);

        // Next S2 slot: prev1 and the pre-reset s2_last (999) read as 0.
        repeat (11) slot();
        yuse_prev1 = 1; xuse_prev2 = 1;
        slot();
        clr_flags();
        chk("post_rst_s2", mod_sum, 0);
        chk("post_rst_use_err", use_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
